// File: rtl/viterbi_pkg.sv
// Shared types and defaults for the Viterbi BER checker.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package viterbi_pkg;

  // Checker alignment state; encoding is visible on state_o.
  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } ber_state_t;

  // Default width of the bit and error counters.
  localparam int BER_CNT_W = 32;

endpackage

// File: rtl/ber_ref_delay.sv
// Reference history for the BER checker: shift register of accepted reference bits,
// fill counter, and tap select hist[cand]. Latency: tap is combinational on the
// pre-edge history. Backpressure: none, every qualified reference bit is accepted.
// Ports: clk, rst (async, active-low); ref_valid/ref_bit push a reference bit;
//   cand selects the tap; tap_bit is hist[cand]; usable is 1 when cand < fill.
module ber_ref_delay #(
  parameter int MAX_LAT = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ref_valid,
  input  logic                       ref_bit,
  input  logic [$clog2(MAX_LAT)-1:0] cand,
  output logic                       tap_bit,
  output logic                       usable
);

  localparam int FILL_W = $clog2(MAX_LAT + 1);

  logic [MAX_LAT-1:0] hist;
  logic [FILL_W-1:0]  fill;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hist <= '0;
      fill <= '0;
    end else if (ref_valid) begin
      hist <= {hist[MAX_LAT-2:0], ref_bit};
      if (fill != FILL_W'(MAX_LAT)) begin
        fill <= fill + FILL_W'(1);
      end
    end
  end

  // A tap is only meaningful once that many reference bits have been shifted in.
  assign tap_bit = hist[cand];
  assign usable  = (FILL_W'(cand) < fill);

endmodule

// File: rtl/viterbi_ber_checker.sv
// Compares decoded bits with the delayed encoder reference, auto-aligning to the
// decoder latency, then counts bits/errors while locked and drops lock on error bursts.
// Latency: outputs registered, one cycle after the decoded sample. Backpressure: none.
// Ports: clk, rst (async, active-low); ref_valid_i/ref_bit_i reference stream;
//   dec_valid_i/dec_bit_i decoded stream; clear_i zeroes the counters;
//   locked_o, latency_o, bit_ct_o, err_ct_o, sync_loss_o (pulse), state_o.
module viterbi_ber_checker
  import viterbi_pkg::*;
#(
  parameter int MAX_LAT  = 64,
  parameter int SYNC_LEN = 32,
  parameter int LOSS_WIN = 64,
  parameter int LOSS_THR = 8,
  parameter int CNT_W    = BER_CNT_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       ref_valid_i,
  input  logic                       ref_bit_i,
  input  logic                       dec_valid_i,
  input  logic                       dec_bit_i,
  input  logic                       clear_i,
  output logic                       locked_o,
  output logic [$clog2(MAX_LAT)-1:0] latency_o,
  output logic [CNT_W-1:0]           bit_ct_o,
  output logic [CNT_W-1:0]           err_ct_o,
  output logic                       sync_loss_o,
  output logic [1:0]                 state_o
);

  localparam int IDX_W   = $clog2(MAX_LAT);
  localparam int MATCH_W = $clog2(SYNC_LEN + 1);
  localparam int WIN_W   = $clog2(LOSS_WIN);
  localparam int ERR_W   = $clog2(LOSS_THR + 1);

  ber_state_t         state, state_nxt;
  logic [IDX_W-1:0]   cand, cand_nxt, cand_inc;
  logic [MATCH_W-1:0] match_ct, match_nxt;
  logic [WIN_W-1:0]   win_ct, win_ct_nxt;
  logic [ERR_W-1:0]   win_err, win_err_nxt;
  logic [IDX_W-1:0]   latency_nxt;
  logic               loss_nxt;
  logic               count_en;
  logic               tap_bit;
  logic               usable;
  logic               mis;

  ber_ref_delay #(
    .MAX_LAT (MAX_LAT)
  ) u_delay (
    .clk       (clk),
    .rst       (rst),
    .ref_valid (ref_valid_i),
    .ref_bit   (ref_bit_i),
    .cand      (cand),
    .tap_bit   (tap_bit),
    .usable    (usable)
  );

  assign mis      = dec_bit_i ^ tap_bit;
  assign cand_inc = (cand == IDX_W'(MAX_LAT - 1)) ? '0 : cand + IDX_W'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state       <= SEARCH;
      cand        <= '0;
      match_ct    <= '0;
      win_ct      <= '0;
      win_err     <= '0;
      latency_o   <= '0;
      locked_o    <= 1'b0;
      sync_loss_o <= 1'b0;
    end else begin
      state       <= state_nxt;
      cand        <= cand_nxt;
      match_ct    <= match_nxt;
      win_ct      <= win_ct_nxt;
      win_err     <= win_err_nxt;
      latency_o   <= latency_nxt;
      locked_o    <= (state_nxt == LOCKED);
      sync_loss_o <= loss_nxt;
    end
  end

  // All FSM activity is gated by dec_valid_i; idle cycles hold every register.
  always_comb begin
    state_nxt   = state;
    cand_nxt    = cand;
    match_nxt   = match_ct;
    win_ct_nxt  = win_ct;
    win_err_nxt = win_err;
    latency_nxt = latency_o;
    loss_nxt    = 1'b0;
    count_en    = 1'b0;
    if (dec_valid_i) begin
      case (state)
        SEARCH: begin
          if (usable && !mis) begin
            state_nxt = VERIFY;
            match_nxt = MATCH_W'(1);
          end else begin
            cand_nxt = cand_inc;
          end
        end
        VERIFY: begin
          if (usable && !mis) begin
            if (match_ct == MATCH_W'(SYNC_LEN - 1)) begin
              state_nxt   = LOCKED;
              latency_nxt = cand;
              match_nxt   = '0;
              win_ct_nxt  = '0;
              win_err_nxt = '0;
            end else begin
              match_nxt = match_ct + MATCH_W'(1);
            end
          end else begin
            state_nxt = SEARCH;
            cand_nxt  = cand_inc;
            match_nxt = '0;
          end
        end
        LOCKED: begin
          count_en = 1'b1;
          // Loss is judged on the window total including this sample.
          if ((win_err + ERR_W'(mis)) == ERR_W'(LOSS_THR)) begin
            state_nxt = SEARCH;
            cand_nxt  = cand_inc;
            loss_nxt  = 1'b1;
          end else if (win_ct == WIN_W'(LOSS_WIN - 1)) begin
            win_ct_nxt  = '0;
            win_err_nxt = '0;
          end else begin
            win_ct_nxt  = win_ct + WIN_W'(1);
            win_err_nxt = win_err + ERR_W'(mis);
          end
        end
        default: begin
          state_nxt = SEARCH;
        end
      endcase
    end
  end

  // Saturating counters; clear_i wins over a same-cycle sample.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_ct_o <= '0;
      err_ct_o <= '0;
    end else if (clear_i) begin
      bit_ct_o <= '0;
      err_ct_o <= '0;
    end else if (count_en) begin
      if (bit_ct_o != '1) begin
        bit_ct_o <= bit_ct_o + CNT_W'(1);
      end
      if (mis && (err_ct_o != '1)) begin
        err_ct_o <= err_ct_o + CNT_W'(1);
      end
    end
  end

  assign state_o = state;

endmodule

// File: tb/tb_viterbi_ber_checker.sv
module tb_viterbi_ber_checker;
  import viterbi_pkg::*;

  localparam int DLY = 37;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ref_valid = 1'b0;
  logic        ref_bit = 1'b0;
  logic        dec_valid = 1'b0;
  logic        dec_bit = 1'b0;
  logic        clear = 1'b0;
  logic        locked;
  logic [5:0]  latency;
  logic [31:0] bit_ct;
  logic [31:0] err_ct;
  logic        sync_loss;
  logic [1:0]  state;

  viterbi_ber_checker dut (
    .clk         (clk),
    .rst         (rst),
    .ref_valid_i (ref_valid),
    .ref_bit_i   (ref_bit),
    .dec_valid_i (dec_valid),
    .dec_bit_i   (dec_bit),
    .clear_i     (clear),
    .locked_o    (locked),
    .latency_o   (latency),
    .bit_ct_o    (bit_ct),
    .err_ct_o    (err_ct),
    .sync_loss_o (sync_loss),
    .state_o     (state)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  typedef struct {
    logic [31:0] b;
    logic [31:0] e;
  } exp_t;

  exp_t       sb[$];
  bit         refq[$];
  logic [6:0] lfsr = 7'h7F;
  int         exp_bit = 0;
  int         exp_err = 0;
  bit         trk_locked = 1'b0;

  // One clock of stimulus; the expected counter values are queued when the sample
  // is driven and compared once the registered outputs have updated.
  task automatic step(input bit ref_en, input bit flip, input bit rand_dec, input bit clr);
    bit   r;
    exp_t e;
    ref_valid = ref_en;
    dec_valid = 1'b0;
    dec_bit   = 1'b0;
    clear     = clr;
    if (ref_en) begin
      r = lfsr[6] ^ lfsr[5];
      lfsr = {lfsr[5:0], r};
      ref_bit = r;
      refq.push_back(r);
      if (refq.size() > DLY) begin
        dec_valid = 1'b1;
        if (rand_dec) dec_bit = 1'($urandom_range(0, 1));
        else          dec_bit = refq[refq.size() - 1 - DLY] ^ flip;
      end
      if (refq.size() > 100) void'(refq.pop_front());
    end
    if (clr) begin
      exp_bit = 0;
      exp_err = 0;
    end else if (trk_locked && dec_valid) begin
      exp_bit++;
      exp_err += int'(flip);
    end
    sb.push_back('{b: 32'(exp_bit), e: 32'(exp_err)});
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("bit_ct", bit_ct, e.b);
    check("err_ct", err_ct, e.e);
    trk_locked = locked;
    ref_valid = 1'b0;
    dec_valid = 1'b0;
    clear     = 1'b0;
  endtask

  task automatic wait_lock(input string tag, output int n);
    int guard;
    guard = 0;
    while (!locked && guard < 3000) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      guard++;
    end
    n = guard;
    check(tag, locked, 1'b1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int loss_seen;
    int loss_at;
    int hits;
    int guard;

    // Reset values
    #1 rst = 1'b0;
    #10;
    check("rst_locked", locked, 1'b0);
    check("rst_latency", latency, 6'd0);
    check("rst_bit_ct", bit_ct, 32'd0);
    check("rst_err_ct", err_ct, 32'd0);
    check("rst_sync_loss", sync_loss, 1'b0);
    check("rst_state", state, SEARCH);
    @(negedge clk);
    rst = 1'b1;

    // 1: clean delayed stream locks at tap 36, no earlier than 37+32 samples
    wait_lock("t1_lock", n);
    check("t1_lock_min", 64'(n >= DLY + 32), 64'd1);
    check("t1_latency", latency, 6'd36);
    check("t1_bit_ct_at_lock", bit_ct, 32'd0);
    // 64 locked samples interleaved with idle cycles; window ends aligned
    for (int i = 0; i < 80; i++) step(i % 5 != 4, 1'b0, 1'b0, 1'b0);
    check("t1_bit_ct", bit_ct, 32'd64);
    check("t1_err_ct", err_ct, 32'd0);

    // 2: one flipped bit per 16 -> 4 errors per 64, lock held
    for (int i = 0; i < 128; i++) begin
      step(1'b1, (i % 16) == 15, 1'b0, 1'b0);
      if (i == 63) check("t2_err_64", err_ct, 32'd4);
    end
    check("t2_err_128", err_ct, 32'd8);
    check("t2_locked", locked, 1'b1);

    // 3: burst of 8 inverted bits at a window start -> loss on the 8th
    loss_seen = 0;
    loss_at = -1;
    for (int i = 0; i < 8; i++) begin
      step(1'b1, 1'b1, 1'b0, 1'b0);
      if (sync_loss) begin
        loss_seen++;
        loss_at = i;
      end
    end
    check("t3_loss_at", loss_at, 7);
    check("t3_state", state, SEARCH);
    check("t3_unlocked", locked, 1'b0);
    check("t3_latency_held", latency, 6'd36);
    guard = 0;
    while (!locked && guard < 3000) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      if (sync_loss) loss_seen++;
      guard++;
    end
    check("t3_relock", locked, 1'b1);
    check("t3_pulses", loss_seen, 1);
    check("t3_latency", latency, 6'd36);

    // 5: clear with a same-cycle sample while locked
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b1);
    check("t5_bit_clr", bit_ct, 32'd0);
    check("t5_err_clr", err_ct, 32'd0);
    step(1'b1, 1'b0, 1'b0, 1'b0);
    check("t5_bit_one", bit_ct, 32'd1);
    check("t5_locked", locked, 1'b1);

    // 6: drop lock, catch VERIFY, then assert reset between clock edges
    for (int i = 0; i < 8; i++) step(1'b1, 1'b1, 1'b0, 1'b0);
    check("t6_unlocked", locked, 1'b0);
    check("t6_err_pre", err_ct, 32'd8);
    guard = 0;
    while (state != VERIFY && guard < 500) begin
      step(1'b1, 1'b0, 1'b0, 1'b0);
      guard++;
    end
    check("t6_in_verify", state, VERIFY);
    #2 rst = 1'b0;
    #1;
    check("t6_locked", locked, 1'b0);
    check("t6_latency", latency, 6'd0);
    check("t6_bit_ct", bit_ct, 32'd0);
    check("t6_err_ct", err_ct, 32'd0);
    check("t6_sync_loss", sync_loss, 1'b0);
    check("t6_state", state, SEARCH);
    exp_bit = 0;
    exp_err = 0;
    trk_locked = 1'b0;
    refq.delete();
    sb.delete();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("t6_cand", dut.cand, 6'd0);
    check("t6_fill", dut.u_delay.fill, 7'd0);

    // 4: independent random decoded stream never locks, counters stay zero
    hits = 0;
    for (int i = 0; i < 10000; i++) begin
      step(1'b1, 1'b0, 1'b1, 1'b0);
      if (locked) hits++;
    end
    check("t4_lock_cycles", hits, 0);
    check("t4_bit_ct", bit_ct, 32'd0);
    check("t4_err_ct", err_ct, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
